// File: rtl/current_clarke_park.sv
// current_clarke_park: offset removal, Clarke and Park transform of phase-A/B ADC samples into d/q current.
// Latency: a trigger sampled at posedge k gives oId/oIq and a one-cycle oCal_done from posedge k+7.
// Backpressure: none; triggers outside IDLE are dropped, so triggers must be at least 8 cycles apart.
//
// Ports:
//   iClk, iRst          clock, synchronous active-high reset
//   iAdc_a, iAdc_b      unsigned 12-bit phase samples
//   iSin, iCos          signed Q2.14 angle terms
//   iSample_en          conversion/calibration trigger (rising edge)
//   iRecal              restart offset calibration (IDLE only)
//   oId, oIq            signed 12-bit d/q currents
//   oCal_done           one-cycle pulse when oId/oIq are updated
//   oOffset_ready       offsets calibrated, conversions enabled
module current_clarke_park #(
  parameter int unsigned CAL_SHIFT = 4,
  parameter logic [15:0] INV_SQRT3 = 16'd9459
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [11:0] iAdc_a,
  input  logic [11:0] iAdc_b,
  input  logic [15:0] iSin,
  input  logic [15:0] iCos,
  input  logic        iSample_en,
  input  logic        iRecal,
  output logic [11:0] oId,
  output logic [11:0] oIq,
  output logic        oCal_done,
  output logic        oOffset_ready
);

  localparam int unsigned ACC_W = 12 + CAL_SHIFT;

  typedef enum logic [3:0] {
    S_IDLE,
    S_OFFS,
    S_BETA,
    S_MUL1,
    S_MUL2,
    S_MUL3,
    S_MUL4,
    S_OUT
  } state_t;

  state_t state_q, state_d;

  logic                    sample_en_q;
  logic [11:0]             adc_a_q, adc_b_q;
  logic signed [15:0]      sin_q, cos_q;
  logic [11:0]             off_a_q, off_b_q;
  logic [ACC_W-1:0]        acc_a_q, acc_b_q;
  logic [CAL_SHIFT-1:0]    cnt_q;
  logic                    ready_q;
  logic signed [11:0]      ia_q, ib_q;
  logic signed [12:0]      alpha_q, beta_q;
  logic signed [28:0]      p_ac_q, p_bs_q, p_as_q, p_bc_q;
  logic [11:0]             id_q, iq_q;
  logic                    done_q;

  // Saturate a 13-bit signed difference to the 12-bit signed range.
  function automatic logic [11:0] sat13(input logic signed [12:0] v);
    if (v > 13'sd2047) begin
      return 12'h7FF;
    end else if (v < -13'sd2048) begin
      return 12'h800;
    end else begin
      return v[11:0];
    end
  endfunction

  // Saturate a 30-bit signed value to the 12-bit signed range.
  function automatic logic [11:0] sat30(input logic signed [29:0] v);
    if (v > 30'sd2047) begin
      return 12'h7FF;
    end else if (v < -30'sd2048) begin
      return 12'h800;
    end else begin
      return v[11:0];
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Trigger qualification
  // ---------------------------------------------------------------------------
  logic trig;
  logic idle_trig;
  logic start_conv;
  logic cal_step;
  logic cal_last;

  always_comb begin
    trig       = iSample_en & ~sample_en_q;
    // iRecal takes priority over a coincident trigger.
    idle_trig  = (state_q == S_IDLE) && trig && !iRecal;
    start_conv = idle_trig && ready_q;
    cal_step   = idle_trig && !ready_q;
    cal_last   = cal_step && (cnt_q == {CAL_SHIFT{1'b1}});
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_conv) state_d = S_OFFS;
      S_OFFS:  state_d = S_BETA;
      S_BETA:  state_d = S_MUL1;
      S_MUL1:  state_d = S_MUL2;
      S_MUL2:  state_d = S_MUL3;
      S_MUL3:  state_d = S_MUL4;
      S_MUL4:  state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (shared multiplier operand select)
  // ---------------------------------------------------------------------------
  logic signed [13:0] beta_sum;
  logic signed [13:0] mul_a;
  logic signed [15:0] mul_b;

  always_comb begin
    // ia + 2*ib spans -6144..6141, hence 14 bits.
    beta_sum = $signed({{2{ia_q[11]}}, ia_q}) + $signed({ib_q[11], ib_q, 1'b0});
    mul_a    = '0;
    mul_b    = '0;
    case (state_q)
      S_BETA: begin
        mul_a = beta_sum;
        mul_b = $signed(INV_SQRT3);
      end
      S_MUL1: begin
        mul_a = {alpha_q[12], alpha_q};
        mul_b = cos_q;
      end
      S_MUL2: begin
        mul_a = {beta_q[12], beta_q};
        mul_b = sin_q;
      end
      S_MUL3: begin
        mul_a = {alpha_q[12], alpha_q};
        mul_b = sin_q;
      end
      S_MUL4: begin
        mul_a = {beta_q[12], beta_q};
        mul_b = cos_q;
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  logic signed [28:0]  mul_a_x, mul_b_x, mul_p;
  logic signed [12:0]  diff_a, diff_b;
  logic [ACC_W-1:0]    acc_sum_a, acc_sum_b;
  logic signed [29:0]  id_sum, iq_sum, id_sh, iq_sh;

  always_comb begin
    mul_a_x   = {{15{mul_a[13]}}, mul_a};
    mul_b_x   = {{13{mul_b[15]}}, mul_b};
    mul_p     = mul_a_x * mul_b_x;

    diff_a    = $signed({1'b0, adc_a_q}) - $signed({1'b0, off_a_q});
    diff_b    = $signed({1'b0, adc_b_q}) - $signed({1'b0, off_b_q});

    acc_sum_a = acc_a_q + ACC_W'(iAdc_a);
    acc_sum_b = acc_b_q + ACC_W'(iAdc_b);

    id_sum    = $signed({p_ac_q[28], p_ac_q}) + $signed({p_bs_q[28], p_bs_q});
    iq_sum    = $signed({p_bc_q[28], p_bc_q}) - $signed({p_as_q[28], p_as_q});
    id_sh     = id_sum >>> 14;
    iq_sh     = iq_sum >>> 14;
  end

  // ---------------------------------------------------------------------------
  // Datapath and calibration registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk) begin
    if (iRst) begin
      sample_en_q <= 1'b0;
      adc_a_q     <= '0;
      adc_b_q     <= '0;
      sin_q       <= '0;
      cos_q       <= '0;
      off_a_q     <= '0;
      off_b_q     <= '0;
      acc_a_q     <= '0;
      acc_b_q     <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      ia_q        <= '0;
      ib_q        <= '0;
      alpha_q     <= '0;
      beta_q      <= '0;
      p_ac_q      <= '0;
      p_bs_q      <= '0;
      p_as_q      <= '0;
      p_bc_q      <= '0;
      id_q        <= '0;
      iq_q        <= '0;
      done_q      <= 1'b0;
    end else begin
      sample_en_q <= iSample_en;
      done_q      <= (state_q == S_OUT);

      case (state_q)
        S_IDLE: begin
          if (iRecal) begin
            // Offsets are kept; they are overwritten when calibration completes.
            ready_q <= 1'b0;
            cnt_q   <= '0;
            acc_a_q <= '0;
            acc_b_q <= '0;
          end else if (start_conv) begin
            adc_a_q <= iAdc_a;
            adc_b_q <= iAdc_b;
            sin_q   <= iSin;
            cos_q   <= iCos;
          end else if (cal_last) begin
            off_a_q <= acc_sum_a[ACC_W-1:CAL_SHIFT];
            off_b_q <= acc_sum_b[ACC_W-1:CAL_SHIFT];
            ready_q <= 1'b1;
            cnt_q   <= '0;
            acc_a_q <= '0;
            acc_b_q <= '0;
          end else if (cal_step) begin
            acc_a_q <= acc_sum_a;
            acc_b_q <= acc_sum_b;
            cnt_q   <= cnt_q + CAL_SHIFT'(1);
          end
        end
        S_OFFS: begin
          ia_q <= sat13(diff_a);
          ib_q <= sat13(diff_b);
        end
        S_BETA: begin
          alpha_q <= {ia_q[11], ia_q};
          // Arithmetic >>>14 of the product, kept to 13 bits.
          beta_q  <= mul_p[26:14];
        end
        S_MUL1: p_ac_q <= mul_p;
        S_MUL2: p_bs_q <= mul_p;
        S_MUL3: p_as_q <= mul_p;
        S_MUL4: p_bc_q <= mul_p;
        S_OUT: begin
          id_q <= sat30(id_sh);
          iq_q <= sat30(iq_sh);
        end
        default: begin
        end
      endcase
    end
  end

  assign oId           = id_q;
  assign oIq           = iq_q;
  assign oCal_done     = done_q;
  assign oOffset_ready = ready_q;

endmodule

// File: tb/tb_current_clarke_park.sv
// tb_current_clarke_park: scoreboard bench for current_clarke_park.
// Latency: expected results carry the cycle at which oCal_done must appear (trigger cycle + 7).
// Backpressure: none; stimulus respects the 8-cycle minimum trigger spacing.
module tb_current_clarke_park;

  logic        iClk;
  logic        iRst;
  logic [11:0] iAdc_a, iAdc_b;
  logic [15:0] iSin, iCos;
  logic        iSample_en;
  logic        iRecal;
  logic [11:0] oId, oIq;
  logic        oCal_done;
  logic        oOffset_ready;

  current_clarke_park dut (
    .iClk          (iClk),
    .iRst          (iRst),
    .iAdc_a        (iAdc_a),
    .iAdc_b        (iAdc_b),
    .iSin          (iSin),
    .iCos          (iCos),
    .iSample_en    (iSample_en),
    .iRecal        (iRecal),
    .oId           (oId),
    .oIq           (oIq),
    .oCal_done     (oCal_done),
    .oOffset_ready (oOffset_ready)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  typedef struct {
    int id;
    int iq;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  int n_chk    = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  // Model state: calibration accumulators and offsets.
  int m_acc_a = 0, m_acc_b = 0, m_cnt = 0;
  int m_off_a = 0, m_off_b = 0;
  int m_ready = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int clamp12(input longint v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return int'(v);
  endfunction

  task automatic model(input int a, input int b, input int s, input int c,
                       output int id, output int iq);
    longint ia, ib, beta;
    ia   = clamp12(a - m_off_a);
    ib   = clamp12(b - m_off_b);
    beta = ((ia + 2 * ib) * 9459) >>> 14;
    id   = clamp12((ia * c + beta * s) >>> 14);
    iq   = clamp12((beta * c - ia * s) >>> 14);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge iClk);
  endtask

  // One calibration trigger; oOffset_ready checked right after the sampling edge.
  task automatic cal_trig(input int a, input int b);
    iAdc_a     = 12'(a);
    iAdc_b     = 12'(b);
    iSample_en = 1'b1;
    m_acc_a += a;
    m_acc_b += b;
    m_cnt++;
    if (m_cnt == 16) begin
      m_off_a = m_acc_a >> 4;
      m_off_b = m_acc_b >> 4;
      m_ready = 1;
      m_acc_a = 0;
      m_acc_b = 0;
      m_cnt   = 0;
    end
    tick(1);
    chk("offset_ready", int'(oOffset_ready), m_ready);
    iSample_en = 1'b0;
    tick(1);
  endtask

  task automatic model_recal();
    m_ready = 0;
    m_acc_a = 0;
    m_acc_b = 0;
    m_cnt   = 0;
  endtask

  task automatic push_exp(input int a, input int b, input int s, input int c);
    int eid, eiq;
    model(a, b, s, c, eid, eiq);
    // Driven now at a negedge; sampled at the next posedge k; done seen after posedge k+7.
    sbq.push_back('{eid, eiq, cyc + 8});
  endtask

  task automatic set_vec(input int a, input int b, input int s, input int c);
    iAdc_a = 12'(a);
    iAdc_b = 12'(b);
    iSin   = 16'(s);
    iCos   = 16'(c);
  endtask

  task automatic convert(input int a, input int b, input int s, input int c);
    push_exp(a, b, s, c);
    set_vec(a, b, s, c);
    iSample_en = 1'b1;
    tick(1);
    iSample_en = 1'b0;
    // Inputs may change once the trigger has been sampled.
    set_vec(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
            int'($urandom_range(0, 32768)) - 16384, int'($urandom_range(0, 32768)) - 16384);
    tick(8);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge iClk) begin
    if (oCal_done) begin
      done_cnt++;
      chk("sb_pending", int'(sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
        mon_e = sbq.pop_front();
        chk("id",      int'($signed(oId)), mon_e.id);
        chk("iq",      int'($signed(oIq)), mon_e.iq);
        chk("latency", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int d0;
    iRst       = 1'b1;
    iSample_en = 1'b0;
    iRecal     = 1'b0;
    set_vec(0, 0, 0, 0);
    tick(3);
    chk("rst_id",    int'(oId), 0);
    chk("rst_iq",    int'(oIq), 0);
    chk("rst_done",  int'(oCal_done), 0);
    chk("rst_ready", int'(oOffset_ready), 0);
    iRst = 1'b0;
    tick(2);

    // Calibration at mid-scale: ready rises exactly on the 16th trigger.
    for (int i = 0; i < 16; i++) cal_trig(2048, 2048);
    chk("cal_id_hold", int'(oId), 0);
    chk("cal_iq_hold", int'(oIq), 0);
    tick(2);

    // Directed conversions.
    convert(2148, 2048, 0, 16384);
    convert(2148, 2048, 16384, 0);
    convert(4095, 4095, 0, 16384);
    convert(1948, 2048, 16384, -16384);

    // Level held high with a second edge inside the conversion: one result only.
    d0 = done_cnt;
    push_exp(2148, 2048, 0, 16384);
    set_vec(2148, 2048, 0, 16384);
    iSample_en = 1'b1;
    tick(2);
    iSample_en = 1'b0;
    tick(1);
    iSample_en = 1'b1;
    tick(17);
    iSample_en = 1'b0;
    tick(3);
    chk("held_level_dones", done_cnt - d0, 1);

    // Reset during a conversion aborts it.
    d0 = done_cnt;
    set_vec(2148, 2048, 0, 16384);
    iSample_en = 1'b1;
    tick(1);
    iSample_en = 1'b0;
    tick(3);
    iRst = 1'b1;
    tick(1);
    iRst = 1'b0;
    model_recal();
    m_off_a = 0;
    m_off_b = 0;
    chk("abort_id",    int'(oId), 0);
    chk("abort_iq",    int'(oIq), 0);
    chk("abort_ready", int'(oOffset_ready), 0);
    tick(10);
    chk("abort_no_done", done_cnt - d0, 0);

    // Calibration with varying samples (b average truncates).
    for (int i = 0; i < 16; i++) cal_trig(2000 + (i % 2) * 10, 1990 + i);
    tick(2);
    for (int i = 0; i < 10; i++) begin
      convert(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
              int'($urandom_range(0, 32768)) - 16384, int'($urandom_range(0, 32768)) - 16384);
    end

    // iRecal outside IDLE is ignored.
    push_exp(2500, 1500, 9000, -12000);
    set_vec(2500, 1500, 9000, -12000);
    iSample_en = 1'b1;
    tick(1);
    iSample_en = 1'b0;
    tick(1);
    iRecal = 1'b1;
    tick(1);
    iRecal = 1'b0;
    tick(6);
    chk("recal_busy_ignored", int'(oOffset_ready), 1);

    // iRecal with a coincident trigger in IDLE: recal wins, trigger is dropped.
    d0 = done_cnt;
    set_vec(100, 100, 0, 16384);
    iRecal     = 1'b1;
    iSample_en = 1'b1;
    tick(1);
    iRecal     = 1'b0;
    iSample_en = 1'b0;
    model_recal();
    chk("recal_ready_drop", int'(oOffset_ready), 0);
    tick(2);
    for (int i = 0; i < 16; i++) cal_trig(i, 0);
    chk("recal_no_done", done_cnt - d0, 0);
    tick(2);

    // Small offsets: offset-removal saturation and more mixed vectors.
    convert(4095, 4095, 0, 16384);
    convert(4095, 0, 16384, 0);
    convert(0, 4095, -16384, 0);
    for (int i = 0; i < 4; i++) begin
      convert(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
              int'($urandom_range(0, 32768)) - 16384, int'($urandom_range(0, 32768)) - 16384);
    end

    tick(10);
    chk("sb_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/current_clarke_park.md
Name: current_clarke_park

Overview:
- Upstream feed stage for the current-loop PI controllers. It turns raw phase-A/B ADC samples into signed d/q current feedback.
- Each sample passes through three steps: offset removal, Clarke transform (two-phase, ia+ib+ic=0), then Park transform using externally supplied sin/cos.
- One shared multiplier; fixed-latency sequential FSM. Output oIq feeds the q-axis PI iCurrent_data; oId feeds the d-axis PI.

Parameters:
- CAL_SHIFT, 4, log2 of the number of calibration samples averaged per phase offset (16 samples).
- INV_SQRT3, 16'd9459, 1/sqrt(3) in Q2.14.

Ports:
- iClk  input  1  system clock
- iRst  input  1  synchronous reset, active-high
- iAdc_a  input  12  unsigned phase-A ADC sample
- iAdc_b  input  12  unsigned phase-B ADC sample
- iSin  input  16  signed Q2.14 sin(theta), valid range -16384..16384
- iCos  input  16  signed Q2.14 cos(theta), valid range -16384..16384
- iSample_en  input  1  conversion trigger, rising-edge detected
- iRecal  input  1  restart offset calibration (honoured only in IDLE)
- oId  output  12  signed d-axis current
- oIq  output  12  signed q-axis current
- oCal_done  output  1  one-cycle pulse: new oId/oIq valid
- oOffset_ready  output  1  high once offsets are calibrated

Behaviour:
- Reset (iRst high at posedge): state IDLE; oId=0, oIq=0, oCal_done=0, oOffset_ready=0; offsets=0, cal counter=0, accumulators=0, edge register=0.
- Reset mid-operation aborts with no oCal_done.
- Edge detect: iSample_en is registered every cycle. A trigger is iSample_en=1 with the registered previous value=0.
  - Triggers outside IDLE are ignored; the edge register still updates.
  - A level held high produces exactly one trigger.
- Calibration (oOffset_ready=0, IDLE):
  - Each trigger adds iAdc_a/iAdc_b into 12+CAL_SHIFT-bit accumulators and increments the counter.
  - On the 2^CAL_SHIFT-th trigger: off_a = acc_a>>CAL_SHIFT, off_b likewise (truncate). oOffset_ready is set in that same edge. Counter and accumulators are cleared.
  - No oCal_done during calibration; oId/oIq hold.
- iRecal=1 in IDLE: clear oOffset_ready, counter and accumulators; offsets hold until recalculated. iRecal is ignored in any other state.
- iRecal and a trigger in the same IDLE cycle: iRecal wins and the trigger is dropped.
- Conversion (oOffset_ready=1) FSM, one state per cycle:
  - IDLE: on trigger, latch iAdc_a, iAdc_b, iSin, iCos; go to OFFS.
  - OFFS: ia = adc_a - off_a, ib = adc_b - off_b (13-bit signed), each saturated to [-2048,2047]. Go to BETA.
  - BETA: alpha = ia; beta = ((ia + 2*ib) * INV_SQRT3) >>> 14, kept as 13-bit signed (no saturation). Go to MUL1.
  - MUL1..MUL4: shared multiplier computes alpha*cos, beta*sin, alpha*sin, beta*cos (29-bit products), registered. Go to OUT.
  - OUT: id = (alpha*cos + beta*sin) >>> 14; iq = (beta*cos - alpha*sin) >>> 14. Sums are 30-bit, shifts arithmetic (floor). Each result saturates to [-2048,2047] into oId/oIq. oCal_done=1 for exactly this cycle's output. Go to IDLE.
- Latency: trigger sampled at posedge k → oCal_done high and oId/oIq updated from posedge k+7 (high during the 8th cycle). oCal_done is low otherwise.
- Minimum trigger spacing: 8 cycles. Sample inputs may change after posedge k.

Test Plan:
1. Reset, then 16 triggers with iAdc_a=iAdc_b=2048 → oOffset_ready rises on the 16th trigger edge; no oCal_done; oId=oIq=0.
2. After cal at 2048: iAdc_a=2148, iAdc_b=2048, iCos=16384, iSin=0, trigger → 8th cycle oCal_done=1, oId=100, oIq=57.
3. Same currents, iSin=16384, iCos=0 → oId=57, oIq=-100.
4. Saturation: iAdc_a=iAdc_b=4095, iCos=16384, iSin=0 → beta=3545 internal; oId=2047, oIq=2047 (clamped).
5. iSample_en held high 20 cycles, plus a second edge at cycle 3 → exactly one oCal_done.
6. iRst asserted at cycle 4 of a conversion → no oCal_done, oId=oIq=0, oOffset_ready=0. iRecal in IDLE → oOffset_ready drops and recalibrates after 16 triggers.
